odd_multiple_combiner: RTL and testbench

- Sequential shift-add multiplier on the consumer side of the 8-way odd-multiple splitter.
- Accepts the eight precomputed odd multiples of a sample (x, 3x, 5x … 15x) together with an unsigned coefficient.
- Rebuilds x*coef one 4-bit coefficient nibble per clock by selecting and shifting one odd multiple.
- Serves as the multiplier-less tap engine for the FIR datapath.

---
 rtl/odd_multiple_combiner_if.sv | 35 +++
 rtl/odd_multiple_combiner.sv | 135 +++++++++++++
 tb/tb_odd_multiple_combiner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/odd_multiple_combiner_if.sv
// Request/response bundle between the odd-multiple splitter side and the combiner.
// The master drives requests and out_ready; the slave (combiner) returns the product.
interface odd_multiple_combiner_if #(
    parameter int MULT_WIDTH     = 21,
    parameter int COEF_WIDTH     = 16,
    parameter int OUT_DATA_WIDTH = 33
);
    logic                      in_valid;
    logic                      in_ready;
    logic [MULT_WIDTH-1:0]     in_mult1;
    logic [MULT_WIDTH-1:0]     in_mult2;
    logic [MULT_WIDTH-1:0]     in_mult3;
    logic [MULT_WIDTH-1:0]     in_mult4;
    logic [MULT_WIDTH-1:0]     in_mult5;
    logic [MULT_WIDTH-1:0]     in_mult6;
    logic [MULT_WIDTH-1:0]     in_mult7;
    logic [MULT_WIDTH-1:0]     in_mult8;
    logic [COEF_WIDTH-1:0]     in_coef;
    logic                      out_valid;
    logic                      out_ready;
    logic [OUT_DATA_WIDTH-1:0] out_data;
    logic                      busy;

    modport master (
        output in_valid, in_mult1, in_mult2, in_mult3, in_mult4,
               in_mult5, in_mult6, in_mult7, in_mult8, in_coef, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_mult1, in_mult2, in_mult3, in_mult4,
               in_mult5, in_mult6, in_mult7, in_mult8, in_coef, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/odd_multiple_combiner.sv
// Shift-add multiplier: rebuilds x*coef one coefficient nibble per clock by
// selecting one of the eight precomputed odd multiples and shifting it into place.
module odd_multiple_combiner #(
    parameter int IN_DATA_WIDTH  = 17,
    parameter int MULT_WIDTH     = 21,
    parameter int COEF_WIDTH     = 16,
    parameter int OUT_DATA_WIDTH = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    odd_multiple_combiner_if.slave bus
);
    localparam int NUM_NIB = COEF_WIDTH / 4;
    localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int SH_W    = (COEF_WIDTH > 2) ? $clog2(COEF_WIDTH) : 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Nibble v = m * 2^k with m odd; returns {k, (m-1)/2}. Caller gates v == 0.
    function automatic logic [4:0] decode_nibble(input logic [3:0] v);
        logic [1:0] k;
        logic [3:0] m;
        if (v[0]) begin
            k = 2'd0;
        end else if (v[1]) begin
            k = 2'd1;
        end else if (v[2]) begin
            k = 2'd2;
        end else begin
            k = 2'd3;
        end
        m = v >> k;
        return {k, 3'(m >> 1)};
    endfunction

    logic [1:0]                state_r;
    logic [IDX_W-1:0]          idx_r;
    logic [OUT_DATA_WIDTH-1:0] acc_r;
    logic [COEF_WIDTH-1:0]     coef_r;
    logic [MULT_WIDTH-1:0]     mult_r [8];
    logic [OUT_DATA_WIDTH-1:0] out_data_r;
    logic                      out_valid_r;
    logic                      in_ready_r;
    logic                      busy_r;

    logic [COEF_WIDTH-1:0]     coef_shift_s;
    logic [3:0]                nib_s;
    logic [4:0]                dec_s;
    logic [SH_W-1:0]           shamt_s;
    logic [OUT_DATA_WIDTH-1:0] addend_s;
    logic [OUT_DATA_WIDTH-1:0] sum_s;

    // Current nibble's partial product and the running sum it produces.
    always_comb begin
        coef_shift_s = coef_r >> {idx_r, 2'b00};
        nib_s        = coef_shift_s[3:0];
        dec_s        = decode_nibble(nib_s);
        shamt_s      = SH_W'({idx_r, 2'b00}) + SH_W'(dec_s[4:3]);
        if (nib_s != 4'd0) begin
            addend_s = OUT_DATA_WIDTH'(mult_r[dec_s[2:0]]) << shamt_s;
        end else begin
            addend_s = {OUT_DATA_WIDTH{1'b0}};
        end
        sum_s = acc_r + addend_s;
    end

    // Control FSM, operand capture, accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            acc_r       <= {OUT_DATA_WIDTH{1'b0}};
            coef_r      <= {COEF_WIDTH{1'b0}};
            out_data_r  <= {OUT_DATA_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                mult_r[i] <= {MULT_WIDTH{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mult_r[0]  <= bus.in_mult1;
                        mult_r[1]  <= bus.in_mult2;
                        mult_r[2]  <= bus.in_mult3;
                        mult_r[3]  <= bus.in_mult4;
                        mult_r[4]  <= bus.in_mult5;
                        mult_r[5]  <= bus.in_mult6;
                        mult_r[6]  <= bus.in_mult7;
                        mult_r[7]  <= bus.in_mult8;
                        coef_r     <= bus.in_coef;
                        acc_r      <= {OUT_DATA_WIDTH{1'b0}};
                        idx_r      <= {IDX_W{1'b0}};
                        state_r    <= ST_MUL;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_MUL: begin
                    acc_r <= sum_s;
                    if (idx_r == IDX_W'(NUM_NIB - 1)) begin
                        out_data_r  <= sum_s;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_odd_multiple_combiner.sv
// Scoreboard bench for odd_multiple_combiner: directed products, latency,
// backpressure, asynchronous abort and back-to-back accept spacing.
module tb_odd_multiple_combiner;
    localparam int IW = 17;
    localparam int MW = 21;
    localparam int CW = 16;
    localparam int OW = 33;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    odd_multiple_combiner_if #(.MULT_WIDTH(MW), .COEF_WIDTH(CW), .OUT_DATA_WIDTH(OW)) bus ();

    odd_multiple_combiner #(
        .IN_DATA_WIDTH(IW), .MULT_WIDTH(MW), .COEF_WIDTH(CW), .OUT_DATA_WIDTH(OW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_accept = -100;
    bit          spacing_en = 1'b0;
    bit          have_prev = 1'b0;
    bit          prev_valid = 1'b0;
    logic [63:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic drive_operands(input logic [IW-1:0] x, input logic [CW-1:0] c);
        logic [63:0] xx;
        xx = 64'(x);
        bus.in_mult1 = MW'(xx);
        bus.in_mult2 = MW'(xx * 64'd3);
        bus.in_mult3 = MW'(xx * 64'd5);
        bus.in_mult4 = MW'(xx * 64'd7);
        bus.in_mult5 = MW'(xx * 64'd9);
        bus.in_mult6 = MW'(xx * 64'd11);
        bus.in_mult7 = MW'(xx * 64'd13);
        bus.in_mult8 = MW'(xx * 64'd15);
        bus.in_coef  = c;
    endtask

    // Issue one request, push its expected product, return 1ns after the accept edge.
    task automatic req(input logic [IW-1:0] x, input logic [CW-1:0] c, input logic [63:0] expv);
        bit accepted;
        drive_operands(x, c);
        bus.in_valid = 1'b1;
        exp_q.push_back(expv);
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1'b1;
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 50 && !empty; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1'b1;
        end
        if (!empty) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: accept spacing, output latency and scoreboard comparison.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.in_valid && bus.in_ready) begin
                    if (spacing_en && have_prev) check("accept_spacing", 64'(cyc + 1 - last_accept), 64'd6);
                    last_accept = cyc + 1;
                    have_prev   = 1'b1;
                end
                if (bus.out_valid && !prev_valid) check("latency", 64'(cyc - last_accept), 64'd4);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %0h expected no output", bus.out_data);
                    end else begin
                        check("out_data", 64'(bus.out_data), exp_q.pop_front());
                    end
                end
                prev_valid = bus.out_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [IW-1:0] rx;
        logic [CW-1:0] rc;
        bit            seen;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive_operands(17'd0, 16'd0);
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed products
        req(17'd100, 16'h1234, 64'd466000);
        bus.in_valid = 1'b0;
        drain();
        req(17'h1FFFF, 16'hFFFF, 64'h1_FFFD_0001);
        bus.in_valid = 1'b0;
        drain();
        req(17'd12345, 16'h0000, 64'd0);
        req(17'd1, 16'h8421, 64'd33825);
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: product held, new requests ignored
        bus.out_ready = 1'b0;
        req(17'd5, 16'd1000, 64'd5000);
        bus.in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("bp_out_valid_seen", 64'(seen), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            drive_operands(17'(9 + i), 16'(3 + i));
            @(negedge clk);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_data", 64'(bus.out_data), 64'd5000);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_busy", 64'(bus.busy), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_ready", 64'(bus.in_ready), 64'd1);
        check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset with idx=2 pending
        req(17'd77, 16'h4321, 64'd0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_out_data", 64'(bus.out_data), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req(17'd7, 16'd9, 64'd63);
        bus.in_valid = 1'b0;
        drain();

        // Back-to-back random requests with in_valid held high
        have_prev  = 1'b0;
        spacing_en = 1'b1;
        for (int n = 0; n < 100; n++) begin
            rx = IW'($urandom_range(0, 131071));
            rc = CW'($urandom_range(0, 65535));
            req(rx, rc, 64'(rx) * 64'(rc));
        end
        bus.in_valid = 1'b0;
        drain();
        spacing_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
